// File: rtl/gp_shreg_pkg.sv
// Shared helpers for the tapped shift register: tap-width sizing and the
// elaboration-time depth ceiling.
package gp_shreg_pkg;

    localparam int MAX_DEPTH = 256;

    // $clog2(2) is 1 but $clog2(1) is 0; never return a zero-width select
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/gp_shreg_tap_mux.sv
// One output tap: stage select, out-of-range guard, optional inversion and
// valid flag derived from the registered fill count.
module gp_shreg_tap_mux
    import gp_shreg_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 16,
    parameter bit INVERT = 1'b0,
    parameter int TW     = clog2_min1(DEPTH),
    parameter int FW     = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH*WIDTH-1:0] stages,
    input  logic [TW-1:0]          tap,
    input  logic [FW-1:0]          fill,
    output logic [WIDTH-1:0]       out,
    output logic                   valid
);

    localparam logic [WIDTH-1:0] INV_MASK = {WIDTH{INVERT}};

    logic [WIDTH-1:0] stage_arr [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unpack
            assign stage_arr[gi] = stages[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Taps past the last stage read as zero, uninverted and never valid
    always_comb begin
        out   = '0;
        valid = 1'b0;
        if (int'(tap) < DEPTH) begin
            out   = stage_arr[tap] ^ INV_MASK;
            valid = int'(tap) < int'(fill);
        end
    end

endmodule

// File: rtl/gp_tap_shreg.sv
// WIDTH x DEPTH shift register with two runtime-selectable taps, parallel
// load/readback and a saturating fill counter.
module gp_tap_shreg
    import gp_shreg_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 16,
    parameter bit               OUTA_INVERT = 1'b0,
    parameter bit               OUTB_INVERT = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    localparam int              TW          = clog2_min1(DEPTH),
    localparam int              FW          = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       sin,
    input  logic                   load,
    input  logic [DEPTH*WIDTH-1:0] pdata,
    input  logic [TW-1:0]          tap_a,
    input  logic [TW-1:0]          tap_b,
    output logic [WIDTH-1:0]       outa,
    output logic [WIDTH-1:0]       outb,
    output logic                   outa_valid,
    output logic                   outb_valid,
    output logic [DEPTH*WIDTH-1:0] pout,
    output logic [FW-1:0]          fill
);

    generate
        if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
            $error("gp_tap_shreg: DEPTH must be in 2..256");
        end
    endgenerate

    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [WIDTH-1:0] stage_reg [DEPTH];
    logic [WIDTH-1:0] shift_src [DEPTH];
    logic [FW-1:0]    fill_reg;
    logic [FW-1:0]    fill_next;

    // Each stage: reset > parallel load > shift from its upstream neighbour
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign shift_src[gi] = sin;
            end else begin : g_body
                assign shift_src[gi] = stage_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg[gi] <= RESET_VAL;
                end else if (load) begin
                    stage_reg[gi] <= pdata[gi*WIDTH +: WIDTH];
                end else if (en) begin
                    stage_reg[gi] <= shift_src[gi];
                end
            end

            assign pout[gi*WIDTH +: WIDTH] = stage_reg[gi];
        end
    endgenerate

    always_comb begin
        fill_next = fill_reg;
        if (load) begin
            fill_next = FILL_MAX;
        end else if (en && (fill_reg != FILL_MAX)) begin
            fill_next = fill_reg + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_reg <= '0;
        end else begin
            fill_reg <= fill_next;
        end
    end

    assign fill = fill_reg;

    gp_shreg_tap_mux #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .INVERT (OUTA_INVERT),
        .TW     (TW),
        .FW     (FW)
    ) u_tap_a (
        .stages (pout),
        .tap    (tap_a),
        .fill   (fill_reg),
        .out    (outa),
        .valid  (outa_valid)
    );

    gp_shreg_tap_mux #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .INVERT (OUTB_INVERT),
        .TW     (TW),
        .FW     (FW)
    ) u_tap_b (
        .stages (pout),
        .tap    (tap_b),
        .fill   (fill_reg),
        .out    (outb),
        .valid  (outb_valid)
    );

endmodule

// File: tb/tb_gp_tap_shreg.sv
// Scoreboard bench for gp_tap_shreg: two configurations driven in lockstep
// against an array-based reference model.
module tb_gp_tap_shreg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=1, DEPTH=16, no inversion, RESET_VAL=0
    logic        rst0, en0, load0;
    logic [0:0]  sin0;
    logic [15:0] pdata0;
    logic [3:0]  tap_a0, tap_b0;
    logic [0:0]  outa0, outb0;
    logic        va0, vb0;
    logic [15:0] pout0;
    logic [4:0]  fill0;

    // Instance 1: WIDTH=4, DEPTH=12, outb inverted, RESET_VAL=1
    logic        rst1, en1, load1;
    logic [3:0]  sin1;
    logic [47:0] pdata1;
    logic [3:0]  tap_a1, tap_b1;
    logic [3:0]  outa1, outb1;
    logic        va1, vb1;
    logic [47:0] pout1;
    logic [3:0]  fill1;

    gp_tap_shreg #(
        .WIDTH(1), .DEPTH(16), .OUTA_INVERT(1'b0), .OUTB_INVERT(1'b0), .RESET_VAL(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst0), .en(en0), .sin(sin0), .load(load0), .pdata(pdata0),
        .tap_a(tap_a0), .tap_b(tap_b0), .outa(outa0), .outb(outb0),
        .outa_valid(va0), .outb_valid(vb0), .pout(pout0), .fill(fill0)
    );

    gp_tap_shreg #(
        .WIDTH(4), .DEPTH(12), .OUTA_INVERT(1'b0), .OUTB_INVERT(1'b1), .RESET_VAL(4'h1)
    ) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .sin(sin1), .load(load1), .pdata(pdata1),
        .tap_a(tap_a1), .tap_b(tap_b1), .outa(outa1), .outb(outb1),
        .outa_valid(va1), .outb_valid(vb1), .pout(pout1), .fill(fill1)
    );

    // Reference model configuration and state
    int         depth_c [2] = '{16, 12};
    int         width_c [2] = '{1, 4};
    bit         inva_c  [2] = '{1'b0, 1'b0};
    bit         invb_c  [2] = '{1'b0, 1'b1};
    logic [3:0] rv_c    [2] = '{4'h0, 4'h1};
    logic [3:0] st      [2][16];
    int         fill_m  [2];

    typedef struct {
        int          d;
        int          ta;
        int          tb;
        logic [3:0]  oa;
        logic [3:0]  ob;
        logic        va;
        logic        vb;
        logic [63:0] pout;
        int          fill;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] mask_of(input int d);
        return 4'((1 << width_c[d]) - 1);
    endfunction

    function automatic logic [3:0] tap_val(input int d, input int tap, input bit inv);
        if (tap >= depth_c[d]) return 4'h0;
        return st[d][tap] ^ (inv ? mask_of(d) : 4'h0);
    endfunction

    // Record what the DUT must show this cycle, then advance the model one edge
    task automatic model_step(input int d, input bit r, input bit l, input bit e,
                              input logic [3:0] s, input logic [63:0] pd,
                              input int ta, input int tb);
        exp_t x;
        x.d    = d;
        x.ta   = ta;
        x.tb   = tb;
        x.oa   = tap_val(d, ta, inva_c[d]);
        x.ob   = tap_val(d, tb, invb_c[d]);
        x.va   = (ta < fill_m[d]);
        x.vb   = (tb < fill_m[d]);
        x.fill = fill_m[d];
        x.pout = '0;
        for (int i = 0; i < depth_c[d]; i++)
            x.pout |= 64'(st[d][i]) << (i * width_c[d]);
        sb.push_back(x);

        if (r) begin
            for (int i = 0; i < depth_c[d]; i++) st[d][i] = rv_c[d];
            fill_m[d] = 0;
        end else if (l) begin
            for (int i = 0; i < depth_c[d]; i++)
                st[d][i] = 4'((pd >> (i * width_c[d])) & 64'(mask_of(d)));
            fill_m[d] = depth_c[d];
        end else if (e) begin
            for (int i = depth_c[d] - 1; i > 0; i--) st[d][i] = st[d][i-1];
            st[d][0] = s & mask_of(d);
            fill_m[d] = (fill_m[d] + 1 > depth_c[d]) ? depth_c[d] : fill_m[d] + 1;
        end
    endtask

    task automatic drive();
        model_step(0, rst0, load0, en0, {3'b0, sin0}, {48'b0, pdata0}, int'(tap_a0), int'(tap_b0));
        model_step(1, rst1, load1, en1, sin1, {16'b0, pdata1}, int'(tap_a1), int'(tap_b1));
    endtask

    task automatic idle_all();
        rst0 = 1'b0; en0 = 1'b0; load0 = 1'b0; sin0 = 1'b0; pdata0 = '0;
        rst1 = 1'b0; en1 = 1'b0; load1 = 1'b0; sin1 = 4'h0; pdata1 = '0;
    endtask

    // Monitor: pops one expectation per instance per cycle, away from the edge
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                x = sb.pop_front();
                if (x.d == 0) begin
                    check($sformatf("d0_outa tap=%0d", x.ta), {63'b0, outa0}, {60'b0, x.oa});
                    check($sformatf("d0_outb tap=%0d", x.tb), {63'b0, outb0}, {60'b0, x.ob});
                    check("d0_outa_valid", {63'b0, va0}, {63'b0, x.va});
                    check("d0_outb_valid", {63'b0, vb0}, {63'b0, x.vb});
                    check("d0_pout", {48'b0, pout0}, x.pout);
                    check("d0_fill", {59'b0, fill0}, 64'(x.fill));
                end else begin
                    check($sformatf("d1_outa tap=%0d", x.ta), {60'b0, outa1}, {60'b0, x.oa});
                    check($sformatf("d1_outb tap=%0d", x.tb), {60'b0, outb1}, {60'b0, x.ob});
                    check("d1_outa_valid", {63'b0, va1}, {63'b0, x.va});
                    check("d1_outb_valid", {63'b0, vb1}, {63'b0, x.vb});
                    check("d1_pout", {16'b0, pout1}, x.pout);
                    check("d1_fill", {60'b0, fill1}, 64'(x.fill));
                end
            end
        end
    end

    initial begin
        idle_all();
        rst0 = 1'b1; rst1 = 1'b1;
        tap_a0 = 4'd0; tap_b0 = 4'd1; tap_a1 = 4'd0; tap_b1 = 4'd1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) st[d][i] = rv_c[d];
            fill_m[d] = 0;
        end

        // Reset held for two cycles
        repeat (2) begin
            @(negedge clk);
            rst0 = 1'b1; rst1 = 1'b1;
            drive();
        end

        // Walking one on instance 0; instance 1 shifts random nibbles
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            idle_all();
            en0 = 1'b1; sin0 = (c == 0) ? 1'b1 : 1'b0;
            en1 = 1'b1; sin1 = 4'($urandom);
            drive();
        end

        // en gating: clear, then shift ones with en 1,0,1,0,1
        @(negedge clk);
        idle_all(); rst0 = 1'b1;
        drive();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle_all();
            sin0 = 1'b1; en0 = (c % 2 == 0);
            drive();
        end
        @(negedge clk);
        idle_all(); tap_a0 = 4'd2; tap_b0 = 4'd3;
        drive();
        #3;
        check("gate_fill", {59'b0, fill0}, 64'd3);
        check("gate_pout_low", {61'b0, pout0[2:0]}, 64'h7);

        // Parallel load beats a simultaneous shift; stage i holds i
        @(negedge clk);
        idle_all(); load1 = 1'b1; en1 = 1'b1; sin1 = 4'hF;
        for (int i = 0; i < 12; i++) pdata1[i*4 +: 4] = 4'(i);
        drive();
        @(negedge clk);
        idle_all(); tap_a1 = 4'd5; tap_b1 = 4'd7;
        drive();
        #3;
        check("load_outa", {60'b0, outa1}, 64'h5);
        check("load_outb_inv", {60'b0, outb1}, 64'h8);
        check("load_fill", {60'b0, fill1}, 64'd12);

        // Out-of-range taps on the 12-deep instance
        @(negedge clk);
        idle_all(); tap_a1 = 4'd13; tap_b1 = 4'd12;
        drive();
        #3;
        check("oor_outa", {60'b0, outa1}, 64'h0);
        check("oor_outa_valid", {63'b0, va1}, 64'h0);
        check("oor_outb", {60'b0, outb1}, 64'h0);

        // Reset mid-stream with load and en asserted alongside
        @(negedge clk);
        idle_all(); rst1 = 1'b1;
        drive();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            idle_all(); en1 = 1'b1; sin1 = 4'($urandom); tap_a1 = 4'd3; tap_b1 = 4'd9;
            drive();
        end
        @(negedge clk);
        idle_all(); rst1 = 1'b1; load1 = 1'b1; en1 = 1'b1; pdata1 = {12{4'hA}};
        drive();
        @(negedge clk);
        idle_all();
        drive();
        #3;
        check("midrst_fill", {60'b0, fill1}, 64'd0);
        check("midrst_pout", {16'b0, pout1}, 64'h1111_1111_1111);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst0   = ($urandom_range(0, 39) == 0);
            load0  = ($urandom_range(0, 7) == 0);
            en0    = $urandom_range(0, 1) == 1;
            sin0   = 1'($urandom);
            pdata0 = 16'($urandom);
            tap_a0 = 4'($urandom);
            tap_b0 = 4'($urandom);
            rst1   = ($urandom_range(0, 39) == 0);
            load1  = ($urandom_range(0, 7) == 0);
            en1    = $urandom_range(0, 1) == 1;
            sin1   = 4'($urandom);
            pdata1 = {16'($urandom), 32'($urandom)};
            tap_a1 = 4'($urandom);
            tap_b1 = 4'($urandom);
            drive();
        end

        @(negedge clk);
        idle_all();
        repeat (3) @(negedge clk);
        #4;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
